// File: rtl/tof_shot_sequencer.sv
// tof_shot_sequencer: fires the TDC start strobe once per shot period, collects one
// time-of-flight result per shot and hands back a per-frame hit-sum and hit count
// over a valid/ready handshake. A frame is 2**LOG2_SHOTS shots.
module tof_shot_sequencer #(
    parameter int START_WIDTH = 20,
    parameter int TIMEOUT     = 100,
    parameter int PERIOD      = 200,
    parameter int LOG2_SHOTS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    tdc_start,
    input  logic [12:0]             tdc_tof,
    input  logic                    tdc_valid,
    output logic [13+LOG2_SHOTS-1:0] frame_sum,
    output logic [LOG2_SHOTS:0]     frame_hits,
    output logic                    frame_valid,
    input  logic                    frame_ready
);

    localparam int SUM_W = 13 + LOG2_SHOTS;
    localparam int IDX_W = LOG2_SHOTS + 1;

    // Last cycle of each shot phase, in shot-cycle counter units.
    localparam logic [15:0] FIRE_LAST   = 16'(START_WIDTH - 1);
    localparam logic [15:0] LISTEN_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST    = 16'(PERIOD - 1);
    localparam logic [IDX_W-1:0] SHOT_LAST = IDX_W'((1 << LOG2_SHOTS) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRE   = 3'd1,
        S_LISTEN = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [15:0]        cnt_r;
    logic [IDX_W-1:0]   shot_r;
    logic               shot_hit_r;
    logic [SUM_W-1:0]   sum_r;
    logic [IDX_W-1:0]   hits_r;
    logic               tdc_start_r;
    logic               frame_valid_r;

    logic               capture_s;
    logic               shot_hit_s;
    logic               is_last_s;
    logic               fire_entry_s;
    logic               tdc_start_nxt_s;
    logic               frame_valid_nxt_s;

    // Hit qualification: only the first tdc_valid of a shot, and only while firing or listening.
    always_comb begin
        capture_s = 1'b0;
        if ((state_r == S_FIRE || state_r == S_LISTEN) && tdc_valid && !shot_hit_r) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        shot_hit_s   = shot_hit_r | capture_s;
        is_last_s    = (shot_r == SHOT_LAST);
        fire_entry_s = (next_state_s == S_FIRE) && (state_r != S_FIRE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a hit on the final FIRE cycle still counts as "already hit".
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (enable) next_state_s = S_FIRE;
                else        next_state_s = S_IDLE;
            end
            S_FIRE: begin
                if (cnt_r == FIRE_LAST) begin
                    if (shot_hit_s) begin
                        if (is_last_s) next_state_s = S_DONE;
                        else           next_state_s = S_GAP;
                    end else begin
                        next_state_s = S_LISTEN;
                    end
                end else begin
                    next_state_s = S_FIRE;
                end
            end
            S_LISTEN: begin
                if (capture_s || cnt_r == LISTEN_LAST) begin
                    if (is_last_s) next_state_s = S_DONE;
                    else           next_state_s = S_GAP;
                end else begin
                    next_state_s = S_LISTEN;
                end
            end
            S_GAP: begin
                if (cnt_r == GAP_LAST) next_state_s = S_FIRE;
                else                   next_state_s = S_GAP;
            end
            S_DONE: begin
                if (frame_valid_r && frame_ready) next_state_s = S_IDLE;
                else                              next_state_s = S_DONE;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered strobes line up with the state.
    always_comb begin
        tdc_start_nxt_s   = 1'b0;
        frame_valid_nxt_s = 1'b0;
        if (next_state_s == S_FIRE) tdc_start_nxt_s = 1'b1;
        else                        tdc_start_nxt_s = 1'b0;
        if (next_state_s == S_DONE) frame_valid_nxt_s = 1'b1;
        else                        frame_valid_nxt_s = 1'b0;
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdc_start_r   <= 1'b0;
            frame_valid_r <= 1'b0;
        end else begin
            tdc_start_r   <= tdc_start_nxt_s;
            frame_valid_r <= frame_valid_nxt_s;
        end
    end

    // Shot-cycle counter: restarts at every shot start and runs through FIRE, LISTEN and GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (fire_entry_s) begin
            cnt_r <= 16'd0;
        end else if (state_r == S_IDLE || state_r == S_DONE) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Shot index and per-shot hit flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shot_r     <= '0;
            shot_hit_r <= 1'b0;
        end else begin
            if (state_r == S_IDLE && enable) begin
                shot_r <= '0;
            end else if (state_r == S_GAP && next_state_s == S_FIRE) begin
                shot_r <= shot_r + IDX_W'(1'b1);
            end else begin
                shot_r <= shot_r;
            end
            if (fire_entry_s) begin
                shot_hit_r <= 1'b0;
            end else if (capture_s) begin
                shot_hit_r <= 1'b1;
            end else begin
                shot_hit_r <= shot_hit_r;
            end
        end
    end

    // Frame accumulators; cleared when a frame starts, updated on the hit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r  <= '0;
            hits_r <= '0;
        end else if (state_r == S_IDLE && enable) begin
            sum_r  <= '0;
            hits_r <= '0;
        end else if (capture_s) begin
            sum_r  <= sum_r + SUM_W'(tdc_tof);
            hits_r <= hits_r + IDX_W'(1'b1);
        end else begin
            sum_r  <= sum_r;
            hits_r <= hits_r;
        end
    end

    assign tdc_start   = tdc_start_r;
    assign frame_valid = frame_valid_r;
    assign frame_sum   = sum_r;
    assign frame_hits  = hits_r;

endmodule
